// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running up-counter: flags non +1 steps, wraps and compare matches.
// Optional STICKY_ERR_EN: first mismatch latches error high in a FAULT state until reset.
module count_seq_checker #(
    parameter int          COUNT_W   = 4,
    parameter int          WRAP_W    = 8,
    parameter int          ERR_W     = 8,
    parameter int unsigned MATCH_VAL = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               count_valid,
    input  logic [COUNT_W-1:0] count_in,
    output logic               synced,
    output logic               wrap_pulse,
    output logic [WRAP_W-1:0]  wrap_count,
    output logic               match_pulse,
    output logic               error,
    output logic [ERR_W-1:0]   err_count,
    output logic [1:0]         state_dbg
);

    localparam logic [COUNT_W-1:0] MATCH_V = MATCH_VAL[COUNT_W-1:0];
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [ERR_W-1:0]   ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [COUNT_W-1:0] prev, prev_d;
    logic               is_step, is_zero, mismatch, checking, err_hit;
    logic               synced_d, wrap_pulse_d, match_pulse_d, error_d;
    logic [WRAP_W-1:0]  wrap_count_d;
    logic [ERR_W-1:0]   err_count_d;

    assign state_dbg = state;

    // A zero sample is always legal: it is a wrap, an upstream restart or a held reset.
    always_comb begin
        is_step  = (count_in == prev + COUNT_W'(1));
        is_zero  = (count_in == '0);
        mismatch = !(is_step || is_zero);
        checking = count_valid && (state != S_SYNC);
        err_hit  = checking && mismatch;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_SYNC;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_SYNC:  if (count_valid) state_next = S_TRACK;
`ifdef STICKY_ERR_EN
            S_TRACK: if (err_hit) state_next = S_FAULT;
            S_FAULT: state_next = S_FAULT;
`else
            S_TRACK: state_next = S_TRACK;
`endif
            default: state_next = S_SYNC;
        endcase
    end

    always_comb begin
        prev_d        = count_valid ? count_in : prev;
        synced_d      = synced | count_valid;
        wrap_pulse_d  = checking && (prev == CNT_MAX) && is_zero;
        wrap_count_d  = wrap_count + WRAP_W'(wrap_pulse_d);
        match_pulse_d = count_valid && (count_in == MATCH_V);
        err_count_d   = (err_hit && (err_count != ERR_MAX)) ? err_count + ERR_W'(1) : err_count;
`ifdef STICKY_ERR_EN
        error_d       = error | err_hit;
`else
        error_d       = err_hit;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= '0;
            synced      <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            match_pulse <= 1'b0;
            error       <= 1'b0;
            err_count   <= '0;
        end else begin
            prev        <= prev_d;
            synced      <= synced_d;
            wrap_pulse  <= wrap_pulse_d;
            wrap_count  <= wrap_count_d;
            match_pulse <= match_pulse_d;
            error       <= error_d;
            err_count   <= err_count_d;
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: directed sequences plus randomized traffic vs. a behavioural model.
module tb_count_seq_checker;

    localparam int OW = 20;

`ifdef STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       count_valid = 1'b0;
    logic [3:0] count_in = '0;
    logic       synced, wrap_pulse, match_pulse, error;
    logic [7:0] wrap_count, err_count;
    logic [1:0] state_dbg;

    logic [OW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: history expressed as plain integers.
    bit m_have, m_fault, m_wp, m_mp, m_err;
    int m_prev, m_wc, m_ec;

    count_seq_checker dut (
        .clk(clk), .reset(reset), .count_valid(count_valid), .count_in(count_in),
        .synced(synced), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
        .match_pulse(match_pulse), .error(error), .err_count(err_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] pack_exp();
        return {m_have, m_wp, 8'(m_wc), m_mp, m_err, 8'(m_ec)};
    endfunction

    task automatic model_step(input bit r, input bit v, input int c);
        bit bad;
        if (r) begin
            m_have = 0; m_fault = 0; m_wp = 0; m_mp = 0; m_err = 0;
            m_prev = 0; m_wc = 0; m_ec = 0;
        end else if (v) begin
            m_mp = (c == 9);
            if (!m_have) begin
                m_have = 1; m_wp = 0; bad = 0;
            end else begin
                bad  = !((c == (m_prev + 1) % 16) || (c == 0));
                m_wp = (m_prev == 15) && (c == 0);
                if (m_wp) m_wc = (m_wc + 1) % 256;
                if (bad && m_ec < 255) m_ec = m_ec + 1;
            end
            m_fault = m_fault | bad;
            m_err   = STICKY ? m_fault : bad;
            m_prev  = c;
        end else begin
            m_wp = 0; m_mp = 0;
            m_err = STICKY ? m_fault : 1'b0;
        end
    endtask

    task automatic drive(input bit r, input bit v, input int c);
        @(negedge clk);
        reset       = r;
        count_valid = v;
        count_in    = 4'(c);
        model_step(r, v, c);
        exp_q.push_back(pack_exp());
    endtask

    task automatic feed(input int c);
        drive(1'b0, 1'b1, c);
    endtask

    // Monitor: every edge that follows a driven cycle is one comparison.
    always @(posedge clk) begin
        logic [OW-1:0] got, exp_v;
        #2;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got   = {synced, wrap_pulse, wrap_count, match_pulse, error, err_count};
            n_checks++;
            if (got === exp_v) n_pass++;
            else $display("FAIL outputs @%0t got=%h exp=%h (synced,wrap_p,wrap_cnt,match_p,error,err_cnt) count_in=%0d",
                          $time, got, exp_v, count_in);
        end
    end

    initial begin
        int c;
        int wait_cycles;
        model_step(1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 5);

        // T1: two full sweeps plus trailing zero
        for (int i = 0; i < 32; i++) feed(i % 16);
        feed(0);
        // T2: one gap in the sequence
        drive(1'b1, 1'b0, 0);
        feed(3); feed(4); feed(6); feed(7);
        // T3: restart and hold
        drive(1'b1, 1'b0, 0);
        feed(5); feed(6); feed(0); feed(0); feed(0); feed(1);
        // T4: wrap across idle cycles
        drive(1'b1, 1'b0, 0);
        feed(14); feed(15);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, $urandom_range(15, 0));
        feed(0); feed(1);
        // T5: reset mid-run, then resync at 12
        feed(5); feed(6); feed(7);
        drive(1'b1, 1'b1, 7);
        feed(12); feed(13);
        // T6: sticky vs pulse error
        drive(1'b1, 1'b0, 0);
        feed(1); feed(2); feed(5); feed(6); feed(7);
        drive(1'b0, 1'b0, 0); drive(1'b0, 1'b0, 0);
        // Saturation: alternate 5/9 so every sample after the first mismatches
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 300; i++) feed((i % 2 == 0) ? 5 : 9);

        // Randomized traffic
        drive(1'b1, 1'b0, 0);
        c = 0;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(99, 0);
            if (sel < 1) begin
                drive(1'b1, $urandom_range(1, 0), $urandom_range(15, 0));
            end else if (sel < 20) begin
                drive(1'b0, 1'b0, $urandom_range(15, 0));
            end else begin
                if (sel < 80)      c = (c + 1) % 16;
                else if (sel < 88) c = 0;
                else               c = $urandom_range(15, 0);
                feed(c);
            end
        end
        drive(1'b0, 1'b0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #5;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got=%0d pending exp=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
